add_accumulator: RTL
====================

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter: N_SAMPLES, default 4, samples per accumulation frame; legal range 2..16.
REQ-002 Parameter: ACC_W, default 12, accumulator width; legal range 10..24.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream adder result valid.
REQ-006 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-007 Port: in_sum  input  8  adder sum bits Y[7:0].
REQ-008 Port: in_carry  input  1  adder carryout; operand = {in_carry,in_sum}, 9-bit unsigned, 0..511.
REQ-009 Port: flush  input  1  close current frame early.
REQ-010 Port: out_valid  output  1  frame result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_acc  output  ACC_W  frame sum.
REQ-013 Port: out_count  output  5  samples in the frame, 1..N_SAMPLES.
REQ-014 Port: out_ovf  output  1  frame sum exceeded 2^ACC_W-1.

Function
REQ-015 Two states: ACCUM, HOLD; reset state ACCUM.
REQ-016 ACCUM: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1.
REQ-017 Sample accepted iff in_valid & in_ready at the clock edge; acc <= acc + operand, count <= count+1.
REQ-018 Addition evaluated at ACC_W+1 bits; carry out of bit ACC_W-1 sets sticky ovf for the frame.
REQ-019 Accepted sample making count == N_SAMPLES -> next cycle HOLD, outputs present that frame.
REQ-020 flush=1 in ACCUM with count>0 -> next cycle HOLD with partial frame; a sample accepted in the same cycle is included.
REQ-021 flush=1 in ACCUM with count==0 and no accepted sample: ignored; flush with count==0 plus accepted sample: 1-sample frame.
REQ-022 flush in HOLD: ignored.
REQ-023 out_acc, out_count, out_ovf stable throughout HOLD until handshake.
REQ-024 HOLD with out_ready=1 -> next cycle ACCUM, acc=0, count=0, ovf=0; no sample accepted in that handshake cycle (in_ready=0).
REQ-025 Latency: final sample edge to out_valid high = 1 cycle; no combinational path in_valid->in_ready or out_ready->out_valid.
REQ-026 In ACCUM, out_acc/out_count/out_ovf = 0.

Reset
REQ-027 rst=1 at an edge: state ACCUM, acc=0, count=0, ovf=0, out_valid=0, in_ready=1 after the edge.
REQ-028 rst mid-frame or in HOLD discards partial/pending result; no out_valid emitted for it.
REQ-029 rst takes precedence over in_valid, flush and out_ready in the same cycle.

Configuration
REQ-030 Macro ADD_ACCUMULATOR_SAT_EN defined: on overflow acc clamps to 2^ACC_W-1 and stays there for the frame; out_ovf still set.
REQ-031 Macro undefined: acc wraps modulo 2^ACC_W; out_ovf set on first wrap, sticky for the frame.

Verification
REQ-032 Reset, then 4 samples {0,0x10},{0,0x20},{1,0x00},{0,0x05}, out_ready=1 -> one cycle later out_valid=1, out_acc=0x135, out_count=4, out_ovf=0; next cycle in_ready=1.
REQ-033 2 samples 0x050,0x0A0, flush with 2nd -> out_acc=0x0F0, out_count=2; flush alone at count 0 -> no out_valid.
REQ-034 ACC_W=10, four samples 0x1FF: without macro out_acc=0x3FC(2044 mod 1024=1020), out_ovf=1; with ADD_ACCUMULATOR_SAT_EN out_acc=0x3FF, out_ovf=1.
REQ-035 Frame complete, out_ready=0 for 5 cycles while in_valid=1 -> out_valid held, outputs stable, in_ready=0, no sample lost after out_ready=1.
REQ-036 rst asserted after 2 of 4 samples -> next frame of 4 samples 0x001 gives out_acc=4, out_count=4.
REQ-037 Random in_valid/out_ready, 1000 frames -> every out_acc equals reference sum of accepted operands, no sample dropped or duplicated.

Source files
------------

// File: rtl/add_accumulator.sv
// Frame accumulator for a 9-bit adder result stream: sums N_SAMPLES operands (or fewer on flush)
// and holds the frame result until the downstream handshake. Define ADD_ACCUMULATOR_SAT_EN to clamp on overflow instead of wrapping.
module add_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_carry,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [4:0]       out_count,
  output logic             out_ovf
);

  localparam int               DATA_W     = 9;
  localparam logic [ACC_W-1:0] ACC_MAX    = '1;
  localparam logic [4:0]       COUNT_FULL = 5'(N_SAMPLES);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [DATA_W-1:0]  operand;
  logic [ACC_W:0]     sum_wide;

  // Once saturated, acc sits at ACC_MAX, so any further non-zero operand carries again
  // and a zero operand leaves it at ACC_MAX; no separate sticky term is needed here.
  function automatic logic [ACC_W-1:0] next_acc(input logic [ACC_W:0] sum);
`ifdef ADD_ACCUMULATOR_SAT_EN
    next_acc = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
`else
    next_acc = sum[ACC_W-1:0];
`endif
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign operand   = {in_carry, in_sum};
  assign sum_wide  = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, operand};

  assign out_acc   = out_valid ? acc_q   : '0;
  assign out_count = out_valid ? count_q : '0;
  assign out_ovf   = out_valid & ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (state_q == ACCUM) begin
      if (accept) begin
        acc_d   = next_acc(sum_wide);
        count_d = count_q + 5'd1;
        ovf_d   = ovf_q | sum_wide[ACC_W];
        if ((count_d == COUNT_FULL) || flush) begin
          state_d = HOLD;
        end
      end else if (flush && (count_q != 5'd0)) begin
        state_d = HOLD;
      end
    end else if (out_ready) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
